// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  // shared single-port memory
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );

  // core/memory side
  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for one single-port memory
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;

  state_t state_q, state_d;
  logic [3:0] run_cnt_q, run_cnt_d;

  logic grant_if, grant_d, done;
  logic if_want, d_want;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q, d_ack_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  // A requester whose ack is showing this cycle is still holding req from the
  // finished transaction; it is ignored so it cannot be re-granted at once.
  assign if_want = bus.if_req & ~if_ack_q;
  assign d_want  = bus.d_req  & ~d_ack_q;

  // Grant decision, starvation counter update and transaction completion
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_want && !(if_want && run_cnt_q == RUN_MAX)) begin
          state_d = GNT_D;
          grant_d = 1'b1;
          if (!if_want) begin
            run_cnt_d = 4'd0;
          end else if (run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + 4'd1;
          end
        end else if (if_want) begin
          state_d   = GNT_IF;
          grant_if  = 1'b1;
          run_cnt_d = 4'd0;
        end
      end
      GNT_IF, GNT_D: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data-run counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      run_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Memory command capture on grant, ack pulse and read-data return on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.d_we;
        mem_be_q    <= bus.d_be;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
      end else if (grant_if) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_be_q    <= '1;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
      end
      if (done) begin
        mem_req_q <= 1'b0;
        if (state_q == GNT_IF) begin
          if_ack_q   <= 1'b1;
          if_rdata_q <= bus.mem_rdata;
        end else begin
          d_ack_q   <= 1'b1;
          d_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized model-checked bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          t_valid = 0;
  bit          t_is_d = 0;
  logic [31:0] t_addr = 0, t_wdata = 0;
  logic        t_we = 0;
  logic [3:0]  t_be = 0;
  bit          e_if_ack = 0, e_d_ack = 0, e_d_was_load = 0;
  logic [31:0] e_if_rdata = 0, e_d_rdata = 0;
  int          streak = 0;
  int          grants_if = 0, grants_d = 0;
  bit          m_pif, m_pd, m_fw, m_dw;

  always @(posedge clk) begin
    if (rst) begin
      t_valid = 0; e_if_ack = 0; e_d_ack = 0; e_d_was_load = 0;
      e_if_rdata = 0; e_d_rdata = 0; streak = 0;
    end else begin
      m_pif = e_if_ack;
      m_pd  = e_d_ack;
      e_if_ack = 0;
      e_d_ack  = 0;
      if (t_valid) begin
        if (bus.mem_ack) begin
          if (t_is_d) begin
            e_d_ack = 1; e_d_rdata = bus.mem_rdata; e_d_was_load = !t_we;
          end else begin
            e_if_ack = 1; e_if_rdata = bus.mem_rdata;
          end
          t_valid = 0;
        end
      end else begin
        m_fw = bus.if_req && !m_pif;
        m_dw = bus.d_req && !m_pd;
        if (m_dw && !(m_fw && streak >= MAXR)) begin
          t_valid = 1; t_is_d = 1; t_addr = bus.d_addr; t_we = bus.d_we;
          t_be = bus.d_be; t_wdata = bus.d_wdata;
          streak = m_fw ? ((streak + 1 > MAXR) ? MAXR : streak + 1) : 0;
          grants_d++;
        end else if (m_fw) begin
          t_valid = 1; t_is_d = 0; t_addr = bus.if_addr; t_we = 0;
          t_be = 4'hF; t_wdata = 0;
          streak = 0;
          grants_if++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("mem_req", bus.mem_req, t_valid);
    chk("busy", bus.busy, t_valid);
    chk("if_ack", bus.if_ack, e_if_ack);
    chk("d_ack", bus.d_ack, e_d_ack);
    chk("if_rdata", bus.if_rdata, e_if_rdata);
    if (e_d_ack && e_d_was_load) chk("d_rdata", bus.d_rdata, e_d_rdata);
    if (t_valid) begin
      chk("mem_addr", bus.mem_addr, t_addr);
      chk("mem_we", bus.mem_we, t_we);
      chk("mem_be", bus.mem_be, t_be);
      chk("mem_wdata", bus.mem_wdata, t_wdata);
    end
  end

  // ---------------- memory responder ----------------
  int          mem_wait = 0;
  bit          mem_func = 1;
  bit          fixed_en = 0;
  logic [31:0] fixed_val = 0;
  bit          spur_en = 0;
  bit          in_txn = 0;
  int          wcnt = 0;
  int          mem_txns = 0;

  always @(negedge clk) begin
    if (!bus.mem_req) begin
      in_txn = 0;
      bus.mem_ack = spur_en && (($urandom % 5) == 0);
      bus.mem_rdata = $urandom;
    end else begin
      if (!in_txn) begin
        in_txn = 1;
        mem_txns++;
        wcnt = (mem_wait < 0) ? int'($urandom % 4) : mem_wait;
      end
      if (wcnt == 0) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = fixed_en ? fixed_val :
                        mem_func ? (bus.mem_addr ^ 32'hA500_0000) : $urandom;
      end else begin
        wcnt--;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- stimulus ----------------
  int if_rate, d_rate, r;

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);

    // fetch at 0x100, zero-wait memory, req lingers one cycle past ack
    rst = 0; mem_wait = 0; fixed_en = 1; fixed_val = 32'h0000_0013;
    bus.if_req = 1; bus.if_addr = 32'h100;
    @(negedge clk);
    chk("t1_mem_req", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_mem_be", bus.mem_be, 4'hF);
    @(negedge clk);
    chk("t1_if_ack", bus.if_ack, 1);
    chk("t1_if_rdata", bus.if_rdata, 32'h13);
    chk("t1_busy", bus.busy, 0);
    @(negedge clk);
    chk("t1_linger_no_regrant", bus.mem_req, 0);
    chk("t1_ack_once", bus.if_ack, 0);
    bus.if_req = 0;
    @(negedge clk);
    chk("t1_mem_txns", mem_txns, 1);

    // simultaneous load 0x2000 and fetch 0x104: data first
    fixed_en = 0; mem_func = 1;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h2000; bus.d_wdata = 0;
    bus.if_req = 1; bus.if_addr = 32'h104;
    @(negedge clk);
    chk("t2_first_addr", bus.mem_addr, 32'h2000);
    @(negedge clk);
    chk("t2_d_ack", bus.d_ack, 1);
    chk("t2_d_rdata", bus.d_rdata, 32'hA500_2000);
    chk("t2_if_ack_low", bus.if_ack, 0);
    bus.d_req = 0;
    @(negedge clk);
    chk("t2_fetch_req", bus.mem_req, 1);
    chk("t2_fetch_addr", bus.mem_addr, 32'h104);
    @(negedge clk);
    chk("t2_if_ack", bus.if_ack, 1);
    chk("t2_if_rdata", bus.if_rdata, 32'hA500_0104);
    chk("t2_d_rdata_kept", bus.d_rdata, 32'hA500_2000);
    bus.if_req = 0;
    @(negedge clk);
    chk("t2_mem_txns", mem_txns, 3);

    // store with 3 wait cycles
    mem_wait = 3;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h3000; bus.d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_we", bus.mem_we, 1);
      chk("t3_hold_be", bus.mem_be, 4'b0011);
      chk("t3_hold_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("t3_no_ack_yet", bus.d_ack, 0);
    end
    @(negedge clk);
    chk("t3_d_ack", bus.d_ack, 1);
    chk("t3_if_rdata_kept", bus.if_rdata, 32'hA500_0104);
    bus.d_req = 0;
    @(negedge clk);
    chk("t3_ack_once", bus.d_ack, 0);

    // reset in the middle of a data grant
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h4000;
    @(negedge clk);
    chk("t5_granted", bus.mem_req, 1);
    @(negedge clk);
    rst = 1; bus.d_req = 0;
    @(negedge clk);
    chk("t5_mem_req", bus.mem_req, 0);
    chk("t5_mem_we", bus.mem_we, 0);
    chk("t5_mem_be", bus.mem_be, 0);
    chk("t5_mem_addr", bus.mem_addr, 0);
    chk("t5_mem_wdata", bus.mem_wdata, 0);
    chk("t5_if_ack", bus.if_ack, 0);
    chk("t5_if_rdata", bus.if_rdata, 0);
    chk("t5_d_rdata", bus.d_rdata, 0);
    chk("t5_busy", bus.busy, 0);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_late_ack", bus.d_ack, 0);
    end
    mem_wait = 0;
    bus.d_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_served", bus.d_ack, 1);
    chk("t5_rdata", bus.d_rdata, 32'hA500_4000);
    bus.d_req = 0;
    @(negedge clk);
    chk("model_grants_d", grants_d, 4);
    chk("model_grants_if", grants_if, 2);

    // randomized traffic: moderate load, then both requesters saturated
    mem_wait = -1; mem_func = 0; spur_en = 1;
    for (int ph = 0; ph < 2; ph++) begin
      if_rate = (ph == 0) ? 40 : 100;
      d_rate  = (ph == 0) ? 50 : 100;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (rst) rst = 0;
        else if (($urandom % 300) == 0) rst = 1;
        if (bus.if_req) begin
          if (bus.if_ack) begin
            r = int'($urandom % 3);
            if (r == 0) bus.if_req = 0;
            else if (r == 2) bus.if_addr = $urandom;
          end
        end else if (int'($urandom % 100) < if_rate) begin
          bus.if_req = 1; bus.if_addr = $urandom;
        end
        if (bus.d_req) begin
          if (bus.d_ack) begin
            r = int'($urandom % 3);
            if (r == 0) bus.d_req = 0;
            else if (r == 2) begin
              bus.d_we = 1'($urandom); bus.d_be = 4'($urandom);
              bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
          end
        end else if (int'($urandom % 100) < d_rate) begin
          bus.d_req = 1; bus.d_we = 1'($urandom); bus.d_be = 4'($urandom);
          bus.d_addr = $urandom; bus.d_wdata = $urandom;
        end
      end
    end
    @(negedge clk);
    rst = 0; bus.if_req = 0; bus.d_req = 0;
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
